// File: rtl/genome_loader.sv
// rtl/genome_loader.sv - framed byte-stream chromosome loader with atomic commit; optional readback under GENOME_READBACK_EN
module genome_loader #(
    parameter int          NUM_LES   = 25,
    parameter int          LE_BITS   = 15,
    parameter int          NUM_OUTS  = 8,
    parameter int          OUT_BITS  = 6,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [NUM_LES*LE_BITS-1:0]    conf_les,
    output logic [NUM_OUTS*OUT_BITS-1:0]  conf_outs,
    output logic                          conf_valid,
    output logic                          load_done,
    output logic                          load_err
`ifdef GENOME_READBACK_EN
    ,
    input  logic                          rb_req,
    output logic [7:0]                    rb_data,
    output logic                          rb_valid,
    input  logic                          rb_ready,
    output logic                          rb_busy
`endif
);
    localparam int LES_W     = NUM_LES * LE_BITS;
    localparam int OUTS_W    = NUM_OUTS * OUT_BITS;
    localparam int TOTAL     = LES_W + OUTS_W;
    localparam int PAY_BYTES = (TOTAL + 7) / 8;
    localparam int CW        = $clog2(PAY_BYTES + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(PAY_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK, S_COMMIT} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_run;
    logic [CW-1:0]      r_cnt;
    logic [7:0]         r_acc;
    logic [TOTAL-1:0]   r_shadow;
    logic [TOTAL-1:0]   r_conf;
    logic               r_conf_valid;
    logic               r_load_err;
    logic               w_fire;
    logic               w_sum_ok;

    // r_run keeps in_ready low for the cycle in which reset is being applied
    assign in_ready   = r_run && (r_state != S_COMMIT);
    assign w_fire     = in_valid && in_ready;
    assign w_sum_ok   = (in_data == r_acc);
    assign conf_les   = r_conf[LES_W-1:0];
    assign conf_outs  = r_conf[TOTAL-1:LES_W];
    assign conf_valid = r_conf_valid;
    assign load_done  = (r_state == S_COMMIT);
    assign load_err   = r_load_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_fire && in_data == SYNC_BYTE) w_next = S_PAYLOAD;
            S_PAYLOAD: if (w_fire && r_cnt == LAST_IDX)    w_next = S_CHECK;
            S_CHECK:   if (w_fire) w_next = w_sum_ok ? S_COMMIT : S_IDLE;
            S_COMMIT:  w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // The active config is loaded on the checksum edge so it is visible in the COMMIT cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run        <= 1'b0;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_shadow     <= '0;
            r_conf       <= '0;
            r_conf_valid <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_run      <= 1'b1;
            r_load_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fire && in_data == SYNC_BYTE) begin
                        r_cnt <= '0;
                        r_acc <= '0;
                    end
                end
                S_PAYLOAD: begin
                    if (w_fire) begin
                        for (int b = 0; b < TOTAL; b++) begin
                            if (r_cnt == CW'(b / 8)) r_shadow[b] <= in_data[b % 8];
                        end
                        r_acc <= r_acc ^ in_data;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (w_fire) begin
                        if (w_sum_ok) begin
                            r_conf       <= r_shadow;
                            r_conf_valid <= 1'b1;
                        end else begin
                            r_load_err   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef GENOME_READBACK_EN
    localparam int RBW = $clog2(PAY_BYTES + 2);
    localparam logic [RBW-1:0] RB_CSUM_IDX = RBW'(PAY_BYTES + 1);

    logic                   r_rb_busy;
    logic [RBW-1:0]         r_rb_idx;
    logic [7:0]             r_rb_acc;
    logic [TOTAL-1:0]       r_rb_snap;
    logic [RBW-1:0]         w_rb_k;
    logic [PAY_BYTES*8-1:0] w_rb_flat;
    logic [7:0]             w_rb_byte;
    logic                   w_rb_is_pay;

    // Stream index 0 is the sync byte, 1..PAY_BYTES payload, then the checksum
    assign w_rb_k      = r_rb_idx - RBW'(1);
    assign w_rb_flat   = {{(PAY_BYTES*8-TOTAL){1'b0}}, r_rb_snap};
    assign w_rb_is_pay = (r_rb_idx != '0) && (r_rb_idx != RB_CSUM_IDX);
    assign rb_valid    = r_rb_busy;
    assign rb_busy     = r_rb_busy;

    always_comb begin
        w_rb_byte = '0;
        if (w_rb_is_pay) w_rb_byte = w_rb_flat[{w_rb_k, 3'b000} +: 8];
    end

    always_comb begin
        rb_data = '0;
        if (r_rb_busy) begin
            if (r_rb_idx == '0)               rb_data = SYNC_BYTE;
            else if (r_rb_idx == RB_CSUM_IDX) rb_data = r_rb_acc;
            else                              rb_data = w_rb_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rb_busy <= 1'b0;
            r_rb_idx  <= '0;
            r_rb_acc  <= '0;
            r_rb_snap <= '0;
        end else if (!r_rb_busy) begin
            if (rb_req) begin
                r_rb_busy <= 1'b1;
                r_rb_idx  <= '0;
                r_rb_acc  <= '0;
                r_rb_snap <= r_conf;
            end
        end else if (rb_ready) begin
            if (w_rb_is_pay) r_rb_acc <= r_rb_acc ^ w_rb_byte;
            if (r_rb_idx == RB_CSUM_IDX) r_rb_busy <= 1'b0;
            r_rb_idx <= r_rb_idx + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_genome_loader.sv
// tb/tb_genome_loader.sv - scoreboard bench for genome_loader
module tb_genome_loader;
    localparam int LES_W  = 375;
    localparam int OUTS_W = 48;
    localparam int PB     = 53;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [LES_W-1:0]  conf_les;
    logic [OUTS_W-1:0] conf_outs;
    logic              conf_valid, load_done, load_err;
`ifdef GENOME_READBACK_EN
    logic              rb_req = 1'b0, rb_ready = 1'b0;
    logic [7:0]        rb_data;
    logic              rb_valid, rb_busy;
    logic [7:0]        rb_sb[$];
`endif

    genome_loader dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .conf_les(conf_les), .conf_outs(conf_outs), .conf_valid(conf_valid),
        .load_done(load_done), .load_err(load_err)
`ifdef GENOME_READBACK_EN
        , .rb_req(rb_req), .rb_data(rb_data), .rb_valid(rb_valid), .rb_ready(rb_ready), .rb_busy(rb_busy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                is_err;
        bit                cv;
        logic [LES_W-1:0]  les;
        logic [OUTS_W-1:0] outs;
    } exp_t;

    exp_t              sb[$];
    int                n_cmp = 0;
    int                n_bad = 0;
    logic [LES_W-1:0]  cur_les = '0;
    logic [OUTS_W-1:0] cur_outs = '0;
    bit                cur_cv = 1'b0;
    logic [7:0]        pay [PB];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [423:0] flat();
        logic [423:0] p;
        for (int k = 0; k < PB; k++) p[8*k +: 8] = pay[k];
        return p;
    endfunction

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        for (n = 0; !in_ready && n < 100; n++) @(negedge clk);
        if (n >= 100) timeout("in_ready_wait");
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] cs, input bit gaps, input bit ok);
        logic [423:0] p;
        exp_t e;
        p = flat();
        if (ok) begin
            cur_les  = p[374:0];
            cur_outs = p[422:375];
            cur_cv   = 1'b1;
        end
        e.is_err = !ok;
        e.cv     = cur_cv;
        e.les    = cur_les;
        e.outs   = cur_outs;
        sb.push_back(e);
        send(8'hA5, gaps ? int'($urandom_range(1, 5)) : 0);
        for (int k = 0; k < PB; k++) send(pay[k], gaps ? int'($urandom_range(1, 5)) : 0);
        send(cs, 0);
        chk("pulse_latency", {load_done, load_err}, ok ? 2'b10 : 2'b01);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (load_done || load_err)) begin
                if (sb.size() == 0) begin
                    timeout("unexpected_pulse");
                end else begin
                    e = sb.pop_front();
                    chk("pulse_kind", {load_done, load_err}, e.is_err ? 2'b01 : 2'b10);
                    chk("sb_conf_les", conf_les, e.les);
                    chk("sb_conf_outs", conf_outs, e.outs);
                    chk("sb_conf_valid", conf_valid, e.cv);
                    if (!e.is_err) begin
                        chk("ready_low_commit", in_ready, 1'b0);
                        @(negedge clk);
                        chk("ready_high_after", in_ready, 1'b1);
                    end
                end
            end
        end
    end

`ifdef GENOME_READBACK_EN
    initial begin : rb_monitor
        logic [7:0] x;
        forever begin
            @(negedge clk);
            if (rb_valid && rb_ready) begin
                if (rb_sb.size() == 0) begin
                    timeout("rb_unexpected");
                end else begin
                    x = rb_sb.pop_front();
                    chk("rb_byte", rb_data, x);
                end
            end
        end
    end
`endif

    initial begin : main
        repeat (3) @(posedge clk);
        #1;
        chk("rst_les", conf_les, '0);
        chk("rst_outs", conf_outs, '0);
        chk("rst_flags", {conf_valid, load_done, load_err, in_ready}, 4'b0000);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_rst", in_ready, 1'b1);

        send(8'h3C, 0);
        send(8'h11, 0);
        for (int k = 0; k < PB; k++) pay[k] = 8'h00;
        pay[0] = 8'h07;
        send_frame(8'h07, 1'b0, 1'b1);
        chk("f1_les_lo", conf_les[14:0], 15'h0007);
        chk("f1_rest_zero", {conf_outs, conf_les[374:15]}, '0);
        chk("f1_conf_valid", conf_valid, 1'b1);

        send_frame(8'h06, 1'b0, 1'b0);
        @(negedge clk);
        chk("f2_les_kept", conf_les[14:0], 15'h0007);
        chk("f2_no_done", load_done, 1'b0);

        for (int k = 0; k < PB; k++) pay[k] = 8'(k);
        send_frame(8'h34, 1'b1, 1'b1);
        chk("f3_les_lo", conf_les[14:0], 15'h0100);
        chk("f3_outs0", conf_outs[5:0], 6'h1E);

        send(8'hA5, 0);
        for (int k = 0; k < 20; k++) send(8'(k + 1), 0);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_les", conf_les, '0);
        chk("midrst_outs", conf_outs, '0);
        chk("midrst_flags", {conf_valid, in_ready}, 2'b00);
        cur_les = '0;
        cur_outs = '0;
        cur_cv = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);

        for (int k = 0; k < PB; k++) pay[k] = 8'hA5;
        send_frame(8'hA5, 1'b0, 1'b1);
        chk("f4_les_lo", conf_les[14:0], 15'h25A5);
        chk("f4_outs7", conf_outs[47:42], 6'h12);

`ifdef GENOME_READBACK_EN
        begin
            logic [7:0] cs;
            cs = 8'h00;
            rb_sb.push_back(8'hA5);
            for (int k = 0; k < PB; k++) begin
                rb_sb.push_back(k == PB - 1 ? 8'h25 : 8'hA5);
                cs = cs ^ (k == PB - 1 ? 8'h25 : 8'hA5);
            end
            rb_sb.push_back(cs);
            @(negedge clk) rb_req = 1'b1;
            @(negedge clk) rb_req = 1'b0;
            fork
                begin
                    int n;
                    for (n = 0; rb_sb.size() != 0 && n < 2000; n++) begin
                        rb_ready = 1'($urandom_range(0, 1));
                        @(negedge clk);
                    end
                    rb_ready = 1'b0;
                    if (n >= 2000) timeout("rb_drain");
                end
                begin
                    repeat (10) @(negedge clk);
                    for (int k = 0; k < PB; k++) pay[k] = 8'h00;
                    pay[0] = 8'h07;
                    send_frame(8'h07, 1'b0, 1'b1);
                end
            join
            repeat (3) @(negedge clk);
            chk("rb_idle", {rb_busy, rb_valid}, 2'b00);
            chk("rb_commit_les", conf_les[14:0], 15'h0007);
        end
`endif

        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
